// File: rtl/riscv_mdu_pkg.sv
// riscv_mdu_pkg -- shared definitions for the RV32M multiply/divide unit.
//   MDU_* : RV32M funct3 operation encodings (MUL .. REMU = 0..7).
//   op_is_div   : operation belongs to the divide class.
//   op_is_rem   : operation returns the remainder.
//   op_signed_a : rs1 is interpreted as two's complement.
//   op_signed_b : rs2 is interpreted as two's complement.
package riscv_mdu_pkg;

   localparam logic [2:0] MDU_MUL    = 3'd0;
   localparam logic [2:0] MDU_MULH   = 3'd1;
   localparam logic [2:0] MDU_MULHSU = 3'd2;
   localparam logic [2:0] MDU_MULHU  = 3'd3;
   localparam logic [2:0] MDU_DIV    = 3'd4;
   localparam logic [2:0] MDU_DIVU   = 3'd5;
   localparam logic [2:0] MDU_REM    = 3'd6;
   localparam logic [2:0] MDU_REMU   = 3'd7;

   function automatic logic op_is_div(input logic [2:0] op);
      logic v;
      case (op)
         MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU: v = 1'b1;
         default:                              v = 1'b0;
      endcase
      return v;
   endfunction

   function automatic logic op_is_rem(input logic [2:0] op);
      logic v;
      case (op)
         MDU_REM, MDU_REMU: v = 1'b1;
         default:           v = 1'b0;
      endcase
      return v;
   endfunction

   // MUL is treated as signed; its low half is identical either way.
   function automatic logic op_signed_a(input logic [2:0] op);
      logic v;
      case (op)
         MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM: v = 1'b1;
         default:                                         v = 1'b0;
      endcase
      return v;
   endfunction

   function automatic logic op_signed_b(input logic [2:0] op);
      logic v;
      case (op)
         MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: v = 1'b1;
         default:                             v = 1'b0;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/riscv_mdu_sign.sv
// riscv_mdu_sign -- conditional two's-complement negation.
// Used both to take the magnitude of a signed operand and to restore the
// sign of a product, quotient or remainder.
//   i_val [W-1:0] : input value
//   i_neg         : 1 = negate, 0 = pass through
//   o_val [W-1:0] : result, modulo 2^W
module riscv_mdu_sign #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_val,
   input  logic         i_neg,
   output logic [W-1:0] o_val
);

   logic [W-1:0] w_negated;

   assign w_negated = ~i_val + {{(W-1){1'b0}}, 1'b1};
   assign o_val     = i_neg ? w_negated : i_val;

endmodule

// File: rtl/riscv_mdu.sv
// riscv_mdu -- iterative RV32M multiply/divide unit, one result bit per cycle.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operation handshake (in_ready high only when idle)
//   op [2:0]            : RV32M funct3
//   a, b [XLEN-1:0]     : rs1 / rs2 operands
//   flush               : synchronous kill of the operation in flight
//   out_valid/out_ready : result handshake (out_valid high only when done)
//   result [XLEN-1:0]   : registered result, stable while waiting for out_ready
module riscv_mdu #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);
   import riscv_mdu_pkg::*;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] ZERO    = {XLEN{1'b0}};

   logic [1:0]        r_state;
   logic [2:0]        r_op;
   logic [CNT_W-1:0]  r_cnt;
   logic [XLEN-1:0]   r_opnd;    // multiplicand |a| or divisor |b|
   logic [2*XLEN-1:0] r_acc;     // multiply: {partial high, remaining multiplier bits}
   logic [XLEN-1:0]   r_quot;    // divide: dividend bits shift out MSB, quotient bits shift in LSB
   logic [XLEN-1:0]   r_rem;     // divide: partial remainder (always < divisor)
   logic              r_neg_q;   // negate product / quotient
   logic              r_neg_r;   // negate remainder (follows dividend)
   logic [XLEN-1:0]   r_result;

   logic              w_a_neg;
   logic              w_b_neg;
   logic [XLEN-1:0]   w_a_abs;
   logic [XLEN-1:0]   w_b_abs;
   logic              w_b_zero;
   logic              w_ovf;
   logic              w_special;
   logic [XLEN-1:0]   w_special_res;

   logic [XLEN-1:0]   w_mul_add;
   logic [XLEN:0]     w_mul_hi;
   logic [2*XLEN-1:0] w_acc_next;

   logic [XLEN:0]     w_trial;
   logic              w_ge;
   logic [XLEN-1:0]   w_diff;
   logic [XLEN-1:0]   w_rem_next;
   logic [XLEN-1:0]   w_quot_next;

   logic [2*XLEN-1:0] w_prod_fix;
   logic [XLEN-1:0]   w_quot_fix;
   logic [XLEN-1:0]   w_rem_fix;
   logic [XLEN-1:0]   w_final;

   // ---------------- operand magnitudes ----------------
   assign w_a_neg = op_signed_a(op) & a[XLEN-1];
   assign w_b_neg = op_signed_b(op) & b[XLEN-1];

   riscv_mdu_sign #(.W(XLEN)) u_sign_a (.i_val(a), .i_neg(w_a_neg), .o_val(w_a_abs));
   riscv_mdu_sign #(.W(XLEN)) u_sign_b (.i_val(b), .i_neg(w_b_neg), .o_val(w_b_abs));

   // ---------------- single-cycle divide cases ----------------
   assign w_b_zero  = (b == ZERO);
   assign w_ovf     = op_signed_b(op) & (a == MIN_NEG) & (b == ALL_ONE);
   assign w_special = op_is_div(op) & (w_b_zero | w_ovf);

   // Result for divide-by-zero and signed overflow, which skip iteration.
   always_comb begin
      w_special_res = ZERO;
      if (w_b_zero) begin
         w_special_res = op_is_rem(op) ? a : ALL_ONE;
      end else begin
         w_special_res = op_is_rem(op) ? ZERO : a;
      end
   end

   // ---------------- shift-add multiply step ----------------
   // Multiplier bits sit in the low half and are consumed LSB-first; the
   // carry-extended high half shifts right together with them.
   assign w_mul_add  = r_acc[0] ? r_opnd : ZERO;
   assign w_mul_hi   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_mul_add};
   assign w_acc_next = {w_mul_hi, r_acc[XLEN-1:1]};

   // ---------------- restoring divide step ----------------
   // The XLEN+1-bit trial remainder can reach 2*divisor-1; when it is at
   // least the divisor the difference is below 2^XLEN, so XLEN bits suffice.
   assign w_trial     = {r_rem, r_quot[XLEN-1]};
   assign w_ge        = (w_trial >= {1'b0, r_opnd});
   assign w_diff      = w_trial[XLEN-1:0] - r_opnd;
   assign w_rem_next  = w_ge ? w_diff : w_trial[XLEN-1:0];
   assign w_quot_next = {r_quot[XLEN-2:0], w_ge};

   // ---------------- sign restoration on the final step ----------------
   riscv_mdu_sign #(.W(2*XLEN)) u_sign_p (.i_val(w_acc_next),  .i_neg(r_neg_q), .o_val(w_prod_fix));
   riscv_mdu_sign #(.W(XLEN))   u_sign_q (.i_val(w_quot_next), .i_neg(r_neg_q), .o_val(w_quot_fix));
   riscv_mdu_sign #(.W(XLEN))   u_sign_r (.i_val(w_rem_next),  .i_neg(r_neg_r), .o_val(w_rem_fix));

   // Select the architectural result from the sign-corrected datapath.
   always_comb begin
      w_final = ZERO;
      case (r_op)
         MDU_MUL:                        w_final = w_prod_fix[XLEN-1:0];
         MDU_MULH, MDU_MULHSU, MDU_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
         MDU_DIV, MDU_DIVU:              w_final = w_quot_fix;
         MDU_REM, MDU_REMU:              w_final = w_rem_fix;
         default:                        w_final = ZERO;
      endcase
   end

   // State machine, operand latch and iteration datapath.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_op     <= MDU_MUL;
         r_cnt    <= {CNT_W{1'b0}};
         r_opnd   <= ZERO;
         r_acc    <= {(2*XLEN){1'b0}};
         r_quot   <= ZERO;
         r_rem    <= ZERO;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= ZERO;
      end else if (flush) begin
         r_state <= ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_op    <= op;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_a_neg;
                  r_opnd  <= op_is_div(op) ? w_b_abs : w_a_abs;
                  r_acc   <= {ZERO, w_b_abs};
                  r_quot  <= w_a_abs;
                  r_rem   <= ZERO;
                  if (w_special) begin
                     r_result <= w_special_res;
                     r_state  <= ST_DONE;
                  end else begin
                     r_cnt   <= CNT_W'(XLEN - 1);
                     r_state <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               r_acc  <= w_acc_next;
               r_quot <= w_quot_next;
               r_rem  <= w_rem_next;
               if (r_cnt == {CNT_W{1'b0}}) begin
                  r_result <= w_final;
                  r_state  <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign result    = r_result;

endmodule

// File: tb/tb_riscv_mdu.sv
// tb_riscv_mdu -- self-checking bench for riscv_mdu (XLEN = 32).
// Expected results come from a plain-arithmetic RV32M model.
module tb_riscv_mdu;

   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      tb_op;
   logic [XLEN-1:0] tb_a;
   logic [XLEN-1:0] tb_b;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;

   int checks = 0;
   int errors = 0;

   riscv_mdu #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(tb_op), .a(tb_a), .b(tb_b), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .result(result)
   );

   always #5 clk = ~clk;

   // RV32M reference using 64-bit integer arithmetic.
   function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      longint sa, sb, p;
      longint unsigned ua, ub, up;
      logic [31:0] r;
      sa = $signed(x);
      sb = $signed(y);
      ua = {32'h0, x};
      ub = {32'h0, y};
      r  = 32'h0;
      case (op)
         3'd0: begin p = sa * sb;            r = p[31:0];  end
         3'd1: begin p = sa * sb;            r = p[63:32]; end
         3'd2: begin p = sa * longint'(ub);  r = p[63:32]; end
         3'd3: begin up = ua * ub;           r = up[63:32]; end
         3'd4: begin
            if (y == 32'h0) r = 32'hFFFF_FFFF;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: begin
            if (y == 32'h0) r = 32'hFFFF_FFFF;
            else begin up = ua / ub; r = up[31:0]; end
         end
         3'd6: begin
            if (y == 32'h0) r = x;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: begin
            if (y == 32'h0) r = x;
            else begin up = ua % ub; r = up[31:0]; end
         end
      endcase
      return r;
   endfunction

   // Cycles from accept edge to out_valid: 0 for the short-cut divide cases.
   function automatic int model_lat(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      if (op >= 3'd4 && y == 32'h0) return 0;
      if ((op == 3'd4 || op == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 0;
      return XLEN;
   endfunction

   function automatic logic [31:0] pick();
      int unsigned k;
      k = $urandom_range(0, 9);
      case (k)
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 15));
         4: return 32'h0 - 32'($urandom_range(1, 15));
         default: return 32'($urandom);
      endcase
   endfunction

   // Issue one op, wait (bounded) for out_valid, capture result, hand off.
   task automatic do_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int n);
      @(negedge clk);
      in_valid = 1'b1; tb_op = op; tb_a = x; tb_b = y;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      res = result;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
   endtask

   task automatic test_directed();
      logic [2:0]  t_op [16] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd5, 3'd7, 3'd4, 3'd6,
                                 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd0};
      logic [31:0] t_a  [16] = '{32'd7, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd100, 32'd100,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000,
                                 32'h8000_0000, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] t_b  [16] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd2, 32'd7, 32'd7,
                                 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] t_exp[16] = '{32'hFFFF_FFEB, 32'h0000_0006, 32'h4000_0000, 32'hFFFF_FFFF,
                                 32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0,
                                 32'hFFFF_FFFF, 32'd5, 32'h0, 32'h8000_0000};
      int          t_lat[16] = '{32, 32, 32, 32, 32, 32, 32, 32, 0, 0, 0, 0, 0, 0, 32, 32};
      logic [31:0] res;
      int          n;
      for (int i = 0; i < 16; i++) begin
         do_op(t_op[i], t_a[i], t_b[i], res, n);
         checks++;
         if (res !== t_exp[i]) begin
            errors++;
            $display("FAIL directed_%0d_result: got %h expected %h", i, res, t_exp[i]);
         end
         checks++;
         if (n !== t_lat[i]) begin
            errors++;
            $display("FAIL directed_%0d_latency: got %0d expected %0d", i, n, t_lat[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] x, y, res, exp;
      int          n;
      for (int i = 0; i < 200; i++) begin
         op  = 3'($urandom_range(0, 7));
         x   = pick();
         y   = pick();
         exp = model(op, x, y);
         do_op(op, x, y, res, n);
         checks++;
         if (res !== exp) begin
            errors++;
            $display("FAIL random_result op=%0d a=%h b=%h: got %h expected %h", op, x, y, res, exp);
         end
         checks++;
         if (n !== model_lat(op, x, y)) begin
            errors++;
            $display("FAIL random_latency op=%0d a=%h b=%h: got %0d expected %0d", op, x, y, n, model_lat(op, x, y));
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      in_valid = 1'b1; tb_op = 3'd5; tb_a = 32'd100; tb_b = 32'd7;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      // New op presented while the result is being held.
      in_valid = 1'b1; tb_op = 3'd3; tb_a = 32'd7; tb_b = 32'hFFFF_FFFD;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (result !== 32'd14 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_result_%0d: got %h/%b expected 0000000e/1", i, result, out_valid);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_in_ready_%0d: got %b expected 0", i, in_ready);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL handoff_idle: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL accept_after_handoff: got in_ready=%b expected 0", in_ready);
      end
      n = 0;
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (result !== 32'd6 || n !== XLEN) begin
         errors++;
         $display("FAIL second_op: got %h after %0d expected 00000006 after %0d", result, n, XLEN);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      logic [31:0] res;
      int          n;
      @(negedge clk);
      in_valid = 1'b1; tb_op = 3'd5; tb_a = 32'd1000; tb_b = 32'd3;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_busy: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
      end
      do_op(3'd5, 32'd9, 32'd3, res, n);
      checks++;
      if (res !== 32'd3 || n !== XLEN) begin
         errors++;
         $display("FAIL after_flush: got %h after %0d expected 00000003 after %0d", res, n, XLEN);
      end
      // Flush while a result waits in DONE.
      @(negedge clk);
      in_valid = 1'b1; tb_op = 3'd4; tb_a = 32'd5; tb_b = 32'd0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_done_setup: got out_valid=%b expected 1", out_valid);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_done: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_midbusy();
      logic [31:0] res;
      int          n;
      @(negedge clk);
      in_valid = 1'b1; tb_op = 3'd0; tb_a = 32'd12345; tb_b = 32'd678;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_midbusy: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_op(3'd0, 32'd7, 32'hFFFF_FFFD, res, n);
      checks++;
      if (res !== 32'hFFFF_FFEB) begin
         errors++;
         $display("FAIL after_reset_op: got %h expected ffffffeb", res);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; tb_op = 3'd0; tb_a = 32'h0; tb_b = 32'h0;
      flush = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_flush();
      test_reset_midbusy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
